// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: one TX channel, one RX channel, polled status register.
module mmio_uart #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [1:0]  address,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e          tx_state_q, tx_state_d;
  logic [BAUD_W-1:0]  tx_baud_q, tx_baud_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_q, tx_d;

  rx_state_e          rx_state_q, rx_state_d;
  logic [BAUD_W-1:0]  rx_baud_q, rx_baud_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               rx_meta_q, rx_sync_q;
  logic               rx_commit, rx_ferr_set;

  logic               rx_valid_q, rx_valid_d;
  logic               tx_drop_q, tx_drop_d;
  logic               rx_ovr_q, rx_ovr_d;
  logic               rx_ferr_q, rx_ferr_d;

  logic               tx_busy;
  logic               wr_txdata, wr_status, wr_rxdata;
  logic               unused_in;

  assign wr_txdata = sel & load & (address == 2'd0);
  assign wr_status = sel & load & (address == 2'd1);
  assign wr_rxdata = sel & load & (address == 2'd2);
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx        = tx_q;
  assign unused_in = ^in[15:8];

  // Two-flop synchronizer for the asynchronous rx line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // TX state register and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: a write is accepted only while the registered FSM is idle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (wr_txdata) begin
          tx_byte_d  = in[7:0];
          tx_d       = 1'b0;
          tx_baud_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_d       = tx_byte_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_byte_q[3'(tx_bit_q + 3'd1)];
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // RX state register and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: mid-bit start qualification, 8 LSB-first samples, stop check.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_commit   = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_baud_d  = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud_q == BAUD_HALF) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          if (rx_sync_q) begin
            rx_commit  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1;
            rx_state_d  = RX_BREAK;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Status flags and received byte; a set always beats a clear on the same edge.
  always_comb begin
    rx_byte_d  = rx_commit ? rx_shift_q : rx_byte_q;
    rx_valid_d = rx_commit ? 1'b1 : (wr_rxdata ? 1'b0 : rx_valid_q);
    tx_drop_d  = (wr_txdata & tx_busy) | (tx_drop_q & ~(wr_status & in[2]));
    rx_ovr_d   = (rx_commit & rx_valid_q & ~wr_rxdata) | (rx_ovr_q & ~(wr_status & in[3]));
    rx_ferr_d  = rx_ferr_set | (rx_ferr_q & ~(wr_status & in[4]));
  end

  // Status and receive data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      tx_drop_q  <= tx_drop_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Read mux; reads have no side effects and return zero when deselected.
  always_comb begin
    out = '0;
    if (sel) begin
      case (address)
        2'd0:    out = {8'h00, tx_byte_q};
        2'd1:    out = {11'h000, rx_ferr_q, rx_ovr_q, tx_drop_q, rx_valid_q, tx_busy};
        2'd2:    out = {8'h00, rx_byte_q};
        default: out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed plus randomized bench for mmio_uart against a frame-level reference model.
module tb_mmio_uart;

  localparam int unsigned C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [1:0]  address;
  logic        load;
  logic [15:0] in_d;
  logic [15:0] out_d;
  logic        tx;
  logic        rx;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic       exp_valid, exp_drop, exp_ovr, exp_ferr;
  logic [7:0] exp_byte;

  always #5 clk = ~clk;

  mmio_uart #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .address(address), .load(load),
    .in(in_d), .out(out_d), .tx(tx), .rx(rx)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input logic busy);
    return {11'h000, exp_ferr, exp_ovr, exp_drop, exp_valid, busy};
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0; exp_drop = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_byte = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    sel = 1'b1; load = 1'b0; address = a;
    #1;
    d = out_d;
    sel = 1'b0;
  endtask

  // Register write on the next edge; model tracks W1C and acknowledge effects.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; load = 1'b1; address = a; in_d = d;
    tick();
    sel = 1'b0; load = 1'b0;
    if (a == 2'd1) begin
      if (d[2]) exp_drop = 1'b0;
      if (d[3]) exp_ovr  = 1'b0;
      if (d[4]) exp_ferr = 1'b0;
    end
    if (a == 2'd2) exp_valid = 1'b0;
  endtask

  // Send byte b and check the line cycle by cycle.
  // mode 1: drop-write and W1C mid-frame; mode 2: write on the final stop edge.
  task automatic tx_frame(input logic [7:0] b, input int mode);
    logic [9:0]  f;
    logic [15:0] st;
    f = {1'b1, b, 1'b0};
    wr(2'd0, {8'h00, b});
    for (int k = 0; k < int'(10 * C); k++) begin
      check("tx_line", 16'(tx), 16'(f[k / int'(C)]));
      rd(2'd1, st);
      if (mode == 1 && (k == 9 || k == 10)) check("tx_status_mid", st, exp_status(1'b1));
      else check("tx_busy", 16'(st[0]), 16'd1);
      if (mode == 1 && k == 8) begin
        sel = 1'b1; load = 1'b1; address = 2'd0; in_d = {8'h00, ~b};
      end
      if (mode == 1 && k == 9) begin
        sel = 1'b1; load = 1'b1; address = 2'd1; in_d = 16'h0004;
      end
      if (mode == 2 && k == int'(10 * C) - 1) begin
        sel = 1'b1; load = 1'b1; address = 2'd0; in_d = {8'h00, ~b};
      end
      tick();
      sel = 1'b0; load = 1'b0;
      if (mode == 1 && k == 8) exp_drop = 1'b1;
      if (mode == 1 && k == 9) exp_drop = 1'b0;
      if (mode == 2 && k == int'(10 * C) - 1) exp_drop = 1'b1;
    end
    check("tx_idle_line", 16'(tx), 16'd1);
    rd(2'd1, st);
    check("tx_status_end", st, exp_status(1'b0));
    rd(2'd0, st);
    check("txdata_read", st, {8'h00, b});
  endtask

  // Drive one rx frame; optionally acknowledge on the exact commit edge.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic ack_commit);
    logic [9:0]  f;
    logic [15:0] st;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      repeat (C) tick();
    end
    rx = 1'b1;
    rd(2'd1, st);
    check("rx_pre_commit", st, exp_status(1'b0));
    if (ack_commit) begin
      sel = 1'b1; load = 1'b1; address = 2'd2; in_d = 16'($urandom);
    end
    tick();
    sel = 1'b0; load = 1'b0;
    if (stop) begin
      if (exp_valid && !ack_commit) exp_ovr = 1'b1;
      exp_valid = 1'b1;
      exp_byte  = b;
    end else begin
      exp_ferr = 1'b1;
      if (ack_commit) exp_valid = 1'b0;
    end
    rd(2'd1, st);
    check("rx_status", st, exp_status(1'b0));
    rd(2'd2, st);
    check("rx_data", st, {8'h00, exp_byte});
    repeat (C) tick();
  endtask

  initial begin
    logic [15:0] st;
    logic [7:0]  b;
    logic        stop;

    rst_n = 1'b0; sel = 1'b0; load = 1'b0; address = 2'd0; in_d = 16'h0000; rx = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 16'(tx), 16'd1);
    rd(2'd1, st); check("reset_status", st, 16'h0000);
    rd(2'd0, st); check("reset_txdata", st, 16'h0000);
    rd(2'd2, st); check("reset_rxdata", st, 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: plain frame, busy for exactly 10 bit times
    tx_frame(8'hA5, 0);
    // 2: dropped write mid-frame, W1C of tx_drop
    tx_frame(8'h5A, 1);
    // write on the final stop edge is dropped; the next cycle is accepted back-to-back
    tx_frame(8'h96, 2);
    rd(2'd1, st); check("last_edge_drop", st, 16'h0004);
    tx_frame(8'h3E, 0);
    wr(2'd1, 16'h001C);
    rd(2'd1, st); check("w1c_all", st, 16'h0000);

    // 3: receive, deselected read, offset 3, acknowledge
    rx_frame(8'h3C, 1'b1, 1'b0);
    sel = 1'b0; address = 2'd2; #1;
    check("out_desel", out_d, 16'h0000);
    rd(2'd3, st); check("offset3_read", st, 16'h0000);
    wr(2'd3, 16'hFFFF);
    rd(2'd1, st); check("offset3_write_ignored", st, exp_status(1'b0));
    wr(2'd2, 16'h1234);
    rd(2'd1, st); check("ack_clears_valid", st, 16'h0000);

    // 4: overrun, then acknowledge on the commit edge
    rx_frame(8'h11, 1'b1, 1'b0);
    rx_frame(8'h22, 1'b1, 1'b0);
    rd(2'd1, st); check("overrun_status", st, 16'h000A);
    wr(2'd1, 16'h0008);
    rx_frame(8'h4D, 1'b1, 1'b1);
    rd(2'd1, st); check("commit_beats_ack", st, 16'h0002);

    // 5: framing error, then a one-cycle glitch
    rx_frame(8'hC7, 1'b0, 1'b0);
    rd(2'd1, st); check("frame_err_status", st, 16'h0012);
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (4 * C) tick();
    rd(2'd1, st); check("glitch_status", st, exp_status(1'b0));
    rd(2'd2, st); check("glitch_rxdata", st, {8'h00, exp_byte});
    wr(2'd1, 16'h001C);
    wr(2'd2, 16'h0000);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) wr(2'd2, 16'($urandom));
      if ($urandom_range(0, 1) == 1) wr(2'd1, 16'($urandom));
      rx_frame(b, stop, 1'($urandom_range(0, 1)));
      tx_frame(8'($urandom), 0);
    end

    // 6: reset mid-TX and mid-RX
    wr(2'd1, 16'h001C);
    tx_frame(8'h00, 0);
    sel = 1'b1; load = 1'b1; address = 2'd0; in_d = 16'h00C3;
    tick();
    sel = 1'b0; load = 1'b0;
    rx = 1'b0;
    repeat (3 * C) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_tx", 16'(tx), 16'd1);
    rd(2'd1, st); check("rst_mid_status", st, 16'h0000);
    rd(2'd0, st); check("rst_mid_txdata", st, 16'h0000);
    rd(2'd2, st); check("rst_mid_rxdata", st, 16'h0000);
    rx = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    tx_frame(8'($urandom), 0);
    rx_frame(8'($urandom), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
